// File: rtl/rx_link_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rx_link_pkg
// Purpose : Shared widths, state encodings and state type for the RX link
//           sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package rx_link_pkg;

    localparam int LINK_STATE_W   = 3;
    localparam int COL_SEL_W      = 2;
    localparam int NUM_COL_GROUPS = 4;

    localparam logic [LINK_STATE_W-1:0] LS_IDLE      = 3'd0;
    localparam logic [LINK_STATE_W-1:0] LS_START     = 3'd1;
    localparam logic [LINK_STATE_W-1:0] LS_WAIT_DONE = 3'd2;
    localparam logic [LINK_STATE_W-1:0] LS_SETTLE    = 3'd3;
    localparam logic [LINK_STATE_W-1:0] LS_STREAM    = 3'd4;
    localparam logic [LINK_STATE_W-1:0] LS_FAIL      = 3'd5;

    typedef enum logic [LINK_STATE_W-1:0] {
        ST_IDLE      = LS_IDLE,
        ST_START     = LS_START,
        ST_WAIT_DONE = LS_WAIT_DONE,
        ST_SETTLE    = LS_SETTLE,
        ST_STREAM    = LS_STREAM,
        ST_FAIL      = LS_FAIL
    } link_state_e;

endpackage
`default_nettype wire

// File: rtl/rx_link_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : rx_link_sequencer_if
// Purpose : Control/status bundle between the command decoder side (master)
//           and the link sequencer (slave).
// Rev     : 1.0  initial release
// ============================================================================
interface rx_link_sequencer_if;

    logic                              link_enable;
    logic                              training_done;
    logic                              fval;
    logic [rx_link_pkg::COL_SEL_W-1:0]    column_sel_req;
    logic                              cmd_start_training;
    logic [rx_link_pkg::COL_SEL_W-1:0]    window_column_sel;
    logic                              stream_en;
    logic [rx_link_pkg::LINK_STATE_W-1:0] link_state;
    logic [1:0]                        retry_cnt;
    logic                              train_fail;

    modport master (
        output link_enable, training_done, fval, column_sel_req,
        input  cmd_start_training, window_column_sel, stream_en,
               link_state, retry_cnt, train_fail
    );

    modport slave (
        input  link_enable, training_done, fval, column_sel_req,
        output cmd_start_training, window_column_sel, stream_en,
               link_state, retry_cnt, train_fail
    );

endinterface
`default_nettype wire

// File: rtl/rx_link_timer.sv
`default_nettype none
// ============================================================================
// Module  : rx_link_timer
// Purpose : Loadable up-counter that saturates at a terminal value and flags it.
// Rev     : 1.0  initial release
// ============================================================================
module rx_link_timer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == i_term);
    assign o_tc = w_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (!w_tc) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_link_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rx_link_sequencer
// Purpose : LVDS RX bring-up sequencer: training request with timeout/retry,
//           frame-aligned stream gating and column-group selection.
//           Define AUTO_COLUMN_SCAN_EN to step the column group every frame.
// Rev     : 1.0  initial release
// ============================================================================
module rx_link_sequencer
    import rx_link_pkg::*;
#(
    parameter int TRAIN_TIMEOUT = 65536,
    parameter int MAX_RETRY     = 3,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                clk_rxg,
    input  logic                reset,
    rx_link_sequencer_if.slave  link
);

    localparam int TMR_MAX = (TRAIN_TIMEOUT > SETTLE_CYCLES) ? TRAIN_TIMEOUT : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] C_TO_TERM   = TMR_W'(TRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] C_ST_TERM   = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       C_MAX_RETRY = 2'(MAX_RETRY);

    link_state_e            r_state;
    link_state_e            w_next;
    logic                   r_td_d;
    logic                   r_fval_d;
    logic [1:0]             r_retry;
    logic [1:0]             w_retry_nxt;
    logic                   r_cmd;
    logic                   r_stream;
    logic                   r_fail;
    logic [COL_SEL_W-1:0]   r_col;
    logic                   w_td_rise;
    logic                   w_td_fall;
    logic                   w_fval_fall;
    logic                   w_tmr_load;
    logic                   w_tmr_tc;
    logic [TMR_W-1:0]       w_tmr_term;

    assign w_td_rise   =  link.training_done && !r_td_d;
    assign w_td_fall   = !link.training_done &&  r_td_d;
    assign w_fval_fall = !link.fval          &&  r_fval_d;

    // One timer serves both waits; it restarts from zero on every state change.
    assign w_tmr_term = (r_state == ST_SETTLE) ? C_ST_TERM : C_TO_TERM;
    assign w_tmr_load = (w_next != r_state) || (r_state == ST_IDLE);

    rx_link_timer #(
        .WIDTH      (TMR_W)
    ) u_timer (
        .clk        (clk_rxg),
        .rst        (reset),
        .i_load     (w_tmr_load),
        .i_load_val ('0),
        .i_term     (w_tmr_term),
        .o_tc       (w_tmr_tc)
    );

    always_comb begin
        w_next      = r_state;
        w_retry_nxt = r_retry;
        case (r_state)
            ST_IDLE: begin
                if (link.link_enable) w_next = ST_START;
            end
            ST_START: begin
                w_next = link.link_enable ? ST_WAIT_DONE : ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (!link.link_enable) begin
                    w_next = ST_IDLE;
                end else if (w_td_rise) begin
                    w_next = ST_SETTLE;
                end else if (w_tmr_tc) begin
                    if (r_retry == C_MAX_RETRY) begin
                        w_next = ST_FAIL;
                    end else begin
                        w_next      = ST_START;
                        w_retry_nxt = r_retry + 2'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (!link.link_enable) begin
                    w_next = ST_IDLE;
                end else if (w_td_fall) begin
                    w_next = ST_START;
                end else if (w_tmr_tc && !link.fval) begin
                    w_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_td_fall) begin
                    w_next      = ST_START;
                    w_retry_nxt = 2'd0;
                end else if (!link.link_enable && !link.fval) begin
                    w_next = ST_IDLE;
                end
            end
            ST_FAIL: begin
                if (!link.link_enable) w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (w_next == ST_IDLE) w_retry_nxt = 2'd0;
    end

    always_ff @(posedge clk_rxg) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_td_d   <= 1'b0;
            r_fval_d <= 1'b0;
            r_retry  <= 2'd0;
            r_cmd    <= 1'b0;
            r_stream <= 1'b0;
            r_fail   <= 1'b0;
            r_col    <= '0;
        end else begin
            r_state  <= w_next;
            r_td_d   <= link.training_done;
            r_fval_d <= link.fval;
            r_retry  <= w_retry_nxt;
            r_cmd    <= (r_state == ST_START) && link.link_enable;
            // Streaming only once the state has already settled into STREAM.
            r_stream <= (r_state == ST_STREAM) && (w_next == ST_STREAM);
            if (w_next == ST_FAIL) begin
                r_fail <= 1'b1;
            end else if (w_next == ST_IDLE) begin
                r_fail <= 1'b0;
            end
`ifdef AUTO_COLUMN_SCAN_EN
            if (r_state == ST_STREAM) begin
                if (w_fval_fall) r_col <= r_col + COL_SEL_W'(1);
            end else if (!link.fval) begin
                r_col <= link.column_sel_req;
            end
`else
            if (w_fval_fall || (!link.fval && (r_state != ST_STREAM))) begin
                r_col <= link.column_sel_req;
            end
`endif
        end
    end

    assign link.cmd_start_training = r_cmd;
    assign link.window_column_sel  = r_col;
    assign link.stream_en          = r_stream;
    assign link.link_state         = r_state;
    assign link.retry_cnt          = r_retry;
    assign link.train_fail         = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_rx_link_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_link_sequencer
// Purpose : Scenario bench for rx_link_sequencer with randomized timing.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rx_link_sequencer;

    localparam int T_MAIN  = 200;
    localparam int T_SHORT = 50;
    localparam int SETTLE  = 16;
    localparam int MAXR    = 3;

    logic clk_rxg = 1'b0;
    logic reset   = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk_rxg = ~clk_rxg;

    rx_link_sequencer_if lif ();
    rx_link_sequencer_if lif2 ();

    rx_link_sequencer #(
        .TRAIN_TIMEOUT (T_MAIN),
        .MAX_RETRY     (MAXR),
        .SETTLE_CYCLES (SETTLE)
    ) u_dut (
        .clk_rxg (clk_rxg),
        .reset   (reset),
        .link    (lif.slave)
    );

    rx_link_sequencer #(
        .TRAIN_TIMEOUT (T_SHORT),
        .MAX_RETRY     (MAXR),
        .SETTLE_CYCLES (SETTLE)
    ) u_dut_to (
        .clk_rxg (clk_rxg),
        .reset   (reset),
        .link    (lif2.slave)
    );

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_rxg);
        #1;
    endtask

    task automatic test_reset();
        lif.link_enable  = 1'b0; lif.training_done  = 1'b0; lif.fval  = 1'b0; lif.column_sel_req  = 2'd0;
        lif2.link_enable = 1'b0; lif2.training_done = 1'b0; lif2.fval = 1'b0; lif2.column_sel_req = 2'd0;
        reset = 1'b1;
        step(); step();
        checks++;
        if ({lif.cmd_start_training, lif.window_column_sel, lif.stream_en, lif.link_state,
             lif.retry_cnt, lif.train_fail} !== 10'd0) begin
            failures++;
            $display("FAIL reset_main outputs=%b expected all zero", {lif.cmd_start_training,
                     lif.window_column_sel, lif.stream_en, lif.link_state, lif.retry_cnt, lif.train_fail});
        end
        checks++;
        if ({lif2.cmd_start_training, lif2.window_column_sel, lif2.stream_en, lif2.link_state,
             lif2.retry_cnt, lif2.train_fail} !== 10'd0) begin
            failures++;
            $display("FAIL reset_short outputs nonzero");
        end
        reset = 1'b0;
        step(); step();
        checks++;
        if (lif.link_state !== 3'd0 || lif.cmd_start_training !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold state=%0d cmd=%b expected 0/0", lif.link_state, lif.cmd_start_training);
        end
    endtask

    task automatic test_bringup();
        int pulses = 0;
        int pulse_k = -1;
        int extra = 0;
        int found = -1;
        int dly;
        lif.link_enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (lif.cmd_start_training === 1'b1) begin
                pulses++;
                if (pulse_k < 0) pulse_k = k;
            end
        end
        checks++;
        if (pulse_k != 2) begin
            failures++;
            $display("FAIL bringup_latency pulse at +%0d expected +2", pulse_k);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL bringup_pulses count=%0d expected 1", pulses);
        end
        dly = $urandom_range(20, 150) - 4;
        for (int i = 0; i < dly; i++) begin
            step();
            if (lif.cmd_start_training !== 1'b0 || lif.stream_en !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0 || lif.link_state !== 3'd2) begin
            failures++;
            $display("FAIL bringup_wait stray=%0d state=%0d expected 0/2", extra, lif.link_state);
        end
        lif.training_done = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (lif.stream_en === 1'b1 && found < 0) found = k;
        end
        checks++;
        if (found != SETTLE + 2) begin
            failures++;
            $display("FAIL bringup_stream stream_en at +%0d expected +%0d", found, SETTLE + 2);
        end
        checks++;
        if (lif.retry_cnt !== 2'd0 || lif.link_state !== 3'd4) begin
            failures++;
            $display("FAIL bringup_status retry=%0d state=%0d expected 0/4", lif.retry_cnt, lif.link_state);
        end
    endtask

    task automatic test_column_change();
        logic [1:0] exp_col = 2'd0;
        logic [1:0] newreq;
        int len, chg, blank, bad;
        for (int f = 0; f < 6; f++) begin
            newreq = (f == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            len    = $urandom_range(6, 20);
            chg    = $urandom_range(1, len - 1);
            bad    = 0;
            lif.fval = 1'b1;
            for (int i = 0; i < len; i++) begin
                if (i == chg) lif.column_sel_req = newreq;
                step();
                if (lif.window_column_sel !== exp_col || lif.stream_en !== 1'b1) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL col_midframe frame=%0d col=%0d expected held %0d", f, lif.window_column_sel, exp_col);
            end
            lif.fval = 1'b0;
            step();
            exp_col = newreq;
            checks++;
            if (lif.window_column_sel !== exp_col) begin
                failures++;
                $display("FAIL col_frame_end frame=%0d col=%0d expected %0d", f, lif.window_column_sel, exp_col);
            end
            blank = $urandom_range(2, 6);
            bad = 0;
            for (int i = 0; i < blank; i++) begin
                lif.column_sel_req = 2'($urandom_range(0, 3));
                step();
                if (lif.window_column_sel !== exp_col) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL col_blanking frame=%0d col=%0d expected %0d", f, lif.window_column_sel, exp_col);
            end
        end
    endtask

    task automatic test_loss_of_lock();
        int found = -1;
        lif.training_done = 1'b0;
        step();
        checks++;
        if (lif.stream_en !== 1'b0 || lif.cmd_start_training !== 1'b0) begin
            failures++;
            $display("FAIL lol_drop stream_en=%b cmd=%b expected 0/0", lif.stream_en, lif.cmd_start_training);
        end
        step();
        checks++;
        if (lif.cmd_start_training !== 1'b1 || lif.retry_cnt !== 2'd0) begin
            failures++;
            $display("FAIL lol_restart cmd=%b retry=%0d expected 1/0", lif.cmd_start_training, lif.retry_cnt);
        end
        lif.training_done = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (lif.stream_en === 1'b1 && found < 0) found = k;
        end
        checks++;
        if (found != SETTLE + 2) begin
            failures++;
            $display("FAIL lol_relock stream_en at +%0d expected +%0d", found, SETTLE + 2);
        end
    endtask

    task automatic test_frame_hold();
        int hold;
        int bad = 0;
        lif.training_done = 1'b0;
        step(); step();
        lif.fval = 1'b1;
        lif.training_done = 1'b1;
        hold = SETTLE + $urandom_range(4, 30);
        for (int i = 0; i < hold; i++) begin
            step();
            if (lif.stream_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_midframe stream_en high %0d cycles expected 0", bad);
        end
        lif.fval = 1'b0;
        step();
        checks++;
        if (lif.stream_en !== 1'b0) begin
            failures++;
            $display("FAIL hold_edge stream_en=%b expected 0", lif.stream_en);
        end
        step();
        checks++;
        if (lif.stream_en !== 1'b1) begin
            failures++;
            $display("FAIL hold_release stream_en=%b expected 1", lif.stream_en);
        end
    endtask

`ifdef AUTO_COLUMN_SCAN_EN
    task automatic test_auto_scan();
        logic [1:0] exp_col = 2'd0;
        int bad;
        for (int f = 0; f < 5; f++) begin
            bad = 0;
            lif.fval = 1'b1;
            lif.column_sel_req = 2'($urandom_range(0, 3));
            for (int i = 0; i < $urandom_range(5, 12); i++) begin
                step();
                if (lif.window_column_sel !== exp_col) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL auto_scan frame=%0d col=%0d expected %0d", f, lif.window_column_sel, exp_col);
            end
            lif.fval = 1'b0;
            exp_col = 2'((f + 1) % 4);
            step(); step(); step();
        end
    endtask
`endif

    task automatic test_link_drop();
        int bad = 0;
        logic [1:0] req;
        lif.fval = 1'b1;
        step(); step(); step();
        lif.link_enable = 1'b0;
        for (int i = 0; i < $urandom_range(3, 10); i++) begin
            step();
            if (lif.stream_en !== 1'b1 || lif.link_state !== 3'd4) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL drop_finish_frame stream_en=%b state=%0d expected 1/4", lif.stream_en, lif.link_state);
        end
        lif.fval = 1'b0;
        step();
        checks++;
        if (lif.link_state !== 3'd0 || lif.stream_en !== 1'b0 || lif.retry_cnt !== 2'd0) begin
            failures++;
            $display("FAIL drop_idle state=%0d stream_en=%b expected 0/0", lif.link_state, lif.stream_en);
        end
        req = 2'($urandom_range(0, 3));
        lif.column_sel_req = req;
        step();
        checks++;
        if (lif.window_column_sel !== req) begin
            failures++;
            $display("FAIL idle_col col=%0d expected %0d", lif.window_column_sel, req);
        end
    endtask

    task automatic test_timeout_retry();
        int pc[$];
        int rc[$];
        int fail_seen = -1;
        lif2.link_enable = 1'b1;
        for (int k = 1; k <= 4 * (T_SHORT + 1) + 30; k++) begin
            step();
            if (lif2.cmd_start_training === 1'b1) begin
                pc.push_back(k);
                rc.push_back(int'(lif2.retry_cnt));
            end
            if (lif2.train_fail === 1'b1 && fail_seen < 0) fail_seen = k;
        end
        checks++;
        if (pc.size() != MAXR + 1) begin
            failures++;
            $display("FAIL retry_pulses count=%0d expected %0d", pc.size(), MAXR + 1);
        end else begin
            checks++;
            if (pc[0] != 2) begin
                failures++;
                $display("FAIL retry_first pulse at +%0d expected +2", pc[0]);
            end
            for (int i = 1; i <= MAXR; i++) begin
                checks++;
                if (pc[i] - pc[i-1] != T_SHORT + 1 || rc[i] != i) begin
                    failures++;
                    $display("FAIL retry_spacing idx=%0d gap=%0d retry=%0d expected %0d/%0d",
                             i, pc[i] - pc[i-1], rc[i], T_SHORT + 1, i);
                end
            end
            checks++;
            if (fail_seen != pc[MAXR] + T_SHORT) begin
                failures++;
                $display("FAIL retry_fail_time train_fail at +%0d expected +%0d", fail_seen, pc[MAXR] + T_SHORT);
            end
        end
        checks++;
        if (lif2.link_state !== 3'd5 || lif2.train_fail !== 1'b1 || lif2.stream_en !== 1'b0 || lif2.retry_cnt !== 2'd3) begin
            failures++;
            $display("FAIL retry_fail_state state=%0d fail=%b retry=%0d expected 5/1/3",
                     lif2.link_state, lif2.train_fail, lif2.retry_cnt);
        end
        lif2.link_enable = 1'b0;
        step();
        checks++;
        if (lif2.link_state !== 3'd0 || lif2.train_fail !== 1'b0 || lif2.retry_cnt !== 2'd0) begin
            failures++;
            $display("FAIL retry_clear state=%0d fail=%b retry=%0d expected 0/0/0",
                     lif2.link_state, lif2.train_fail, lif2.retry_cnt);
        end
    endtask

    task automatic test_reset_midop();
        int got_cmd = 0;
        int got_stream = 0;
        lif.training_done = 1'b0;
        lif.fval = 1'b0;
        lif.link_enable = 1'b1;
        for (int k = 0; k < 10 && got_cmd == 0; k++) begin
            step();
            if (lif.cmd_start_training === 1'b1) got_cmd = 1;
        end
        lif.training_done = 1'b1;
        for (int k = 0; k < 40 && got_stream == 0; k++) begin
            step();
            if (lif.stream_en === 1'b1) got_stream = 1;
        end
        lif.column_sel_req = 2'd3;
        lif.fval = 1'b1;
        step(); step(); step();
        lif.fval = 1'b0;
        step(); step();
        lif.fval = 1'b1;
        step(); step(); step(); step();
        checks++;
        if (got_cmd == 0 || got_stream == 0 || lif.stream_en !== 1'b1 || lif.window_column_sel === 2'd0) begin
            failures++;
            $display("FAIL midop_setup cmd=%0d stream=%0d col=%0d expected streaming, col nonzero",
                     got_cmd, got_stream, lif.window_column_sel);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({lif.cmd_start_training, lif.window_column_sel, lif.stream_en, lif.link_state,
             lif.retry_cnt, lif.train_fail} !== 10'd0) begin
            failures++;
            $display("FAIL midop_reset outputs=%b expected all zero", {lif.cmd_start_training,
                     lif.window_column_sel, lif.stream_en, lif.link_state, lif.retry_cnt, lif.train_fail});
        end
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_bringup();
`ifndef AUTO_COLUMN_SCAN_EN
        test_column_change();
`endif
        test_loss_of_lock();
        test_frame_hold();
`ifdef AUTO_COLUMN_SCAN_EN
        test_auto_scan();
`endif
        test_link_drop();
        test_timeout_retry();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_link_sequencer.md
# rx_link_sequencer

Sequences bring-up and operation of the sensor LVDS receive path on `clk_rxg`. It issues the training request with timeout and bounded retry, and holds off image streaming until a full frame boundary. It selects the active column group (`window_column_sel`) and changes it only between frames. It sits between the command/register decoder and the training/column-select/image-buffer datapath.

## Interface
Parameters:
- `TRAIN_TIMEOUT`, default 65536: cycles allowed in WAIT_DONE per attempt (≥2).
- `MAX_RETRY`, default 3: retries after the first attempt before FAIL (≤3).
- `SETTLE_CYCLES`, default 16: cycles held after training_done before streaming may begin (≥1).

Ports:
- `clk_rxg` in 1: single clock. All ports are synchronous to it.
- `reset` in 1: synchronous, active-high reset.
- `link_enable` in 1: level; high requests link up and streaming.
- `training_done` in 1: level from the training block.
- `fval` in 1: frame valid from the image-valid generator.
- `column_sel_req` in 2: requested column group, 0..3.
- `cmd_start_training` out 1: one-cycle pulse to the training block.
- `window_column_sel` out 2: active column group.
- `stream_en` out 1: gates fval/lval into the image buffer.
- `link_state` out 3: current state encoding.
- `retry_cnt` out 2: retries used in the current bring-up.
- `train_fail` out 1: sticky failure flag.

## Operation
- States and encodings: IDLE=0, START=1, WAIT_DONE=2, SETTLE=3, STREAM=4, FAIL=5. Encodings 6 and 7 go to IDLE on the next cycle.
- IDLE: clears the timer. If `link_enable`, go to START.
- START: held for exactly one cycle. `cmd_start_training`=1 in this cycle only. Then go to WAIT_DONE.
- WAIT_DONE: timer counts from 0.
  - On a rising edge of `training_done` (compared against a registered copy), go to SETTLE.
  - When the timer reaches `TRAIN_TIMEOUT`-1: if `retry_cnt`==`MAX_RETRY`, go to FAIL. Otherwise increment `retry_cnt` and go to START.
  - If a done edge and the timeout occur in the same cycle, the done edge wins.
- SETTLE: counts `SETTLE_CYCLES`. After that, go to STREAM on the first cycle with `fval`=0, so streaming never starts mid-frame.
  - If `training_done` falls during SETTLE, go to START. This does not consume a retry.
- STREAM: `stream_en`=1.
  - If `training_done` falls (loss of lock), drop `stream_en` next cycle, clear `retry_cnt`, go to START.
  - If `link_enable` goes low, finish the current frame. Go to IDLE on the `fval` falling edge, or on the next cycle if `fval` is already 0.
- FAIL: `train_fail`=1, `stream_en`=0. It stays until `link_enable`=0, then goes to IDLE. `train_fail` is cleared only on IDLE entry or by `reset`.
- `link_enable` low in START, WAIT_DONE or SETTLE aborts to IDLE on the next cycle. `retry_cnt` clears on IDLE entry.
- Column select: `window_column_sel` loads `column_sel_req` only on an `fval` falling edge, or on any cycle with `fval`=0 while not in STREAM. A request arriving mid-frame takes effect at the end of that frame. A frame-end event in the same cycle as a state change applies both.

## Timing
- All outputs are registered. Any input change is visible on outputs one cycle later.
- Reset values: `cmd_start_training`=0, `window_column_sel`=0, `stream_en`=0, `link_state`=0, `retry_cnt`=0, `train_fail`=0. The timer and edge registers are also cleared.
- Bring-up latency: `link_enable` high at cycle 0 gives `cmd_start_training` at cycle 2.
- Earliest `stream_en`: `SETTLE_CYCLES`+2 cycles after the `training_done` edge, and only if `fval`=0.
- Timeout: with no done edge, consecutive `cmd_start_training` pulses are `TRAIN_TIMEOUT`+1 cycles apart.
- Reset mid-operation: on the next edge, all outputs return to reset values. No pulse is truncated or repeated.

## Configuration
- `AUTO_COLUMN_SCAN_EN` defined: in STREAM, `window_column_sel` increments at every `fval` falling edge and wraps 3→0. `column_sel_req` is ignored while in STREAM and applies as normal otherwise.
- Not defined: `window_column_sel` follows `column_sel_req` only, under the frame-boundary rule above.

## Structure
- Package `rx_link_pkg` holds:
  - state encodings (3-bit constants);
  - `NUM_COL_GROUPS`=4;
  - `COL_SEL_W`=2;
  - `LINK_STATE_W`=3.
- Sub-module `rx_link_timer` is a loadable up-counter with a terminal-count flag. It is reused for both the timeout and settle counts.

## Test plan
- Normal bring-up: set `link_enable`=1 and raise `training_done` 100 cycles after the start pulse, with `fval`=0. Expect one `cmd_start_training` pulse, then `stream_en`=1 exactly 18 cycles after the done edge (`SETTLE_CYCLES`=16), `retry_cnt`=0.
- Timeout and retry: use `TRAIN_TIMEOUT`=50 and keep `training_done`=0. Expect 4 start pulses 51 cycles apart, `retry_cnt` reaching 3, then FAIL with `train_fail`=1. Dropping `link_enable` returns to IDLE and clears `train_fail`.
- Frame-boundary hold: settle completes while `fval`=1. `stream_en` must stay 0 until the cycle after `fval` falls.
- Column change mid-frame: in STREAM, change `column_sel_req` from 0 to 2 while `fval`=1. `window_column_sel` must stay 0 until the cycle after `fval` falls, then read 2.
- Loss of lock: drop `training_done` in STREAM. Expect `stream_en`=0 next cycle, a start pulse two cycles later, and `retry_cnt`=0.
- With `AUTO_COLUMN_SCAN_EN`: over 5 frames, `window_column_sel` reads 0,1,2,3,0. A synchronous `reset` asserted mid-frame zeroes all outputs next cycle.
